// File: rtl/rst_seq_pkg.sv
// Shared types, defaults and width helpers for the reset sequencer.
// ST_ASSERT exists only when RSTSEQ_REVERSE_ASSERT_EN is defined.
package rst_seq_pkg;

  localparam int unsigned DEF_NUM_STAGES  = 3;
  localparam int unsigned DEF_STAGE_DELAY = 16;
  localparam int unsigned DEF_TIMEOUT_CYC = 255;

  typedef enum logic [2:0] {
    ST_HOLD     = 3'd0,
    ST_DELAY    = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_DONE     = 3'd3,
    ST_ERROR    = 3'd4
`ifdef RSTSEQ_REVERSE_ASSERT_EN
    , ST_ASSERT = 3'd5
`endif
  } state_e;

  // Stage index width, never narrower than one bit.
  function automatic int unsigned stg_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Counter wide enough to hold the larger of the two terminal counts.
  function automatic int unsigned cnt_w(input int unsigned dly, input int unsigned tmo);
    return $clog2(((dly > tmo) ? dly : tmo) + 1);
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Control/status bundle between the reset sequencer and the reset domains it drives.
interface reset_sequencer_if
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES = DEF_NUM_STAGES
);
  localparam int unsigned STG_W = stg_w(NUM_STAGES);

  logic                  soft_rst_req;
  logic [NUM_STAGES-1:0] stage_ack;
  logic [NUM_STAGES-1:0] stage_rst_n;
  logic                  seq_done;
  logic                  seq_err;
  logic [STG_W-1:0]      err_stage;

  modport master (
    input  soft_rst_req, stage_ack,
    output stage_rst_n, seq_done, seq_err, err_stage
  );

  modport slave (
    output soft_rst_req, stage_ack,
    input  stage_rst_n, seq_done, seq_err, err_stage
  );
endinterface

// File: rtl/rst_seq_timer.sv
// Clearable up-counter with terminal-count compare; holds at terminal count.
module rst_seq_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] tc_val,
  output logic         tc_c
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc_c) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc_c = (cnt == tc_val);
endmodule

// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES reset domains in order, each after a delay and an ack.
// RSTSEQ_REVERSE_ASSERT_EN: soft reset re-asserts stages one per edge, highest first.
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES  = DEF_NUM_STAGES,
  parameter int unsigned STAGE_DELAY = DEF_STAGE_DELAY,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic               clk,
  input  logic               rst_n,
  reset_sequencer_if.master  bus
);
  localparam int unsigned STG_W = stg_w(NUM_STAGES);
  localparam int unsigned CNT_W = cnt_w(STAGE_DELAY, TIMEOUT_CYC);
  localparam logic [STG_W-1:0] LAST_IDX = STG_W'(NUM_STAGES - 1);
  localparam logic [CNT_W-1:0] DLY_TC   = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] TMO_TC   = CNT_W'(TIMEOUT_CYC - 1);

  state_e                state_q, state_d;
  logic [STG_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] rst_q, rst_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [STG_W-1:0]      err_stage_q, err_stage_d;

  logic                  tmr_clr_c;
  logic                  tmr_en_c;
  logic [CNT_W-1:0]      tmr_tc_val_c;
  logic                  tmr_hit_c;
`ifdef RSTSEQ_REVERSE_ASSERT_EN
  logic                  found_c;
`endif

  // One counter serves both the release delay and the ack timeout.
  assign tmr_tc_val_c = (state_q == ST_WAIT_ACK) ? TMO_TC : DLY_TC;

  rst_seq_timer #(.W(CNT_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr_c),
    .en     (tmr_en_c),
    .tc_val (tmr_tc_val_c),
    .tc_c   (tmr_hit_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HOLD;
      idx_q       <= '0;
      rst_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_stage_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rst_q       <= rst_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_stage_q <= err_stage_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rst_d       = rst_q;
    done_d      = done_q;
    err_d       = err_q;
    err_stage_d = err_stage_q;
    tmr_en_c    = 1'b0;
`ifdef RSTSEQ_REVERSE_ASSERT_EN
    found_c     = 1'b0;
`endif

    unique case (state_q)
      ST_HOLD: begin
        rst_d = '0;
        idx_d = '0;
        if (!bus.soft_rst_req) state_d = ST_DELAY;
      end
      ST_DELAY: begin
        tmr_en_c = 1'b1;
        if (tmr_hit_c) begin
          rst_d[idx_q] = 1'b1;
          state_d      = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        // Ack beats a coinciding timeout.
        if (bus.stage_ack[idx_q]) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + STG_W'(1);
            state_d = ST_DELAY;
          end
        end else begin
          tmr_en_c = 1'b1;
          if (tmr_hit_c) begin
            state_d      = ST_ERROR;
            err_d        = 1'b1;
            err_stage_d  = idx_q;
            rst_d[idx_q] = 1'b0;
          end
        end
      end
      ST_DONE: begin
        rst_d  = '1;
        done_d = 1'b1;
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
`ifdef RSTSEQ_REVERSE_ASSERT_EN
      ST_ASSERT: begin
        done_d      = 1'b0;
        err_d       = 1'b0;
        err_stage_d = '0;
        idx_d       = '0;
        for (int i = int'(NUM_STAGES) - 1; i >= 0; i--) begin
          if (!found_c && rst_q[i]) begin
            rst_d[i] = 1'b0;
            found_c  = 1'b1;
          end
        end
        if (rst_d == '0) state_d = ST_HOLD;
      end
`endif
      default: state_d = ST_HOLD;
    endcase

    // Soft reset overrides ack and timeout from any active state.
    if (bus.soft_rst_req &&
        (state_q inside {ST_DELAY, ST_WAIT_ACK, ST_DONE, ST_ERROR})) begin
`ifdef RSTSEQ_REVERSE_ASSERT_EN
      state_d     = ST_ASSERT;
      idx_d       = idx_q;
      rst_d       = rst_q;
      done_d      = done_q;
      err_d       = err_q;
      err_stage_d = err_stage_q;
`else
      state_d     = ST_HOLD;
      idx_d       = '0;
      rst_d       = '0;
      done_d      = 1'b0;
      err_d       = 1'b0;
      err_stage_d = '0;
`endif
    end

    tmr_clr_c = (state_d != state_q);
  end

  assign bus.stage_rst_n = rst_q;
  assign bus.seq_done    = done_q;
  assign bus.seq_err     = err_q;
  assign bus.err_stage   = err_stage_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: NUM_STAGES=3, STAGE_DELAY=4, TIMEOUT_CYC=8.
module tb_reset_sequencer;
  import rst_seq_pkg::*;

  localparam int unsigned NS = 3;
  localparam int unsigned SD = 4;
  localparam int unsigned TO = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   edge_n   = 0;

  reset_sequencer_if #(.NUM_STAGES(NS)) bus ();

  reset_sequencer #(
    .NUM_STAGES  (NS),
    .STAGE_DELAY (SD),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic run_to(input int e);
    while (edge_n < e) tick();
  endtask

  // Release rst_n between edges; the next posedge is edge 0.
  task automatic release_reset();
    repeat (2) @(posedge clk);
    #3;
    rst_n  = 1'b1;
    edge_n = -1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    release_reset();
  endtask

  initial begin
    bus.soft_rst_req = 1'b0;
    bus.stage_ack    = 3'b111;

    // Async reset before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_stage_rst_n", 32'(bus.stage_rst_n), 0);
    chk("rst_seq_done",    32'(bus.seq_done), 0);
    chk("rst_seq_err",     32'(bus.seq_err), 0);
    chk("rst_err_stage",   32'(bus.err_stage), 0);

    // Power-on with all acks tied high
    release_reset();
    run_to(3);  chk("s1_e3",  32'(bus.stage_rst_n), 0);
    run_to(4);  chk("s1_e4",  32'(bus.stage_rst_n), 1);
    run_to(8);  chk("s1_e8",  32'(bus.stage_rst_n), 1);
    run_to(9);  chk("s1_e9",  32'(bus.stage_rst_n), 3);
    run_to(14); chk("s1_e14", 32'(bus.stage_rst_n), 7);
    chk("s1_done_e14", 32'(bus.seq_done), 0);
    run_to(15); chk("s1_done_e15", 32'(bus.seq_done), 1);

    // DONE ignores acks
    bus.stage_ack = 3'b000;
    run_to(18);
    chk("done_stable_rst", 32'(bus.stage_rst_n), 7);
    chk("done_stable_done", 32'(bus.seq_done), 1);
    bus.stage_ack = 3'b111;

`ifndef RSTSEQ_REVERSE_ASSERT_EN
    // One-cycle soft reset in DONE; HOLD left at edge 20
    bus.soft_rst_req = 1'b1;
    run_to(19);
    chk("s3_rst_e19",  32'(bus.stage_rst_n), 0);
    chk("s3_done_e19", 32'(bus.seq_done), 0);
    bus.soft_rst_req = 1'b0;
    run_to(23); chk("s3_e23", 32'(bus.stage_rst_n), 0);
    run_to(24); chk("s3_e24", 32'(bus.stage_rst_n), 1);
    run_to(29); chk("s3_e29", 32'(bus.stage_rst_n), 3);
    run_to(34); chk("s3_e34", 32'(bus.stage_rst_n), 7);
    run_to(35); chk("s3_done_e35", 32'(bus.seq_done), 1);
`else
    // Reverse re-assertion from DONE
    bus.soft_rst_req = 1'b1;
    run_to(19);
    chk("s6_rst_e19",  32'(bus.stage_rst_n), 7);
    bus.soft_rst_req = 1'b0;
    run_to(20);
    chk("s6_rst_e20",  32'(bus.stage_rst_n), 3);
    chk("s6_done_e20", 32'(bus.seq_done), 0);
    run_to(21); chk("s6_rst_e21", 32'(bus.stage_rst_n), 1);
    run_to(22); chk("s6_rst_e22", 32'(bus.stage_rst_n), 0);
    run_to(26); chk("s6_rst_e26", 32'(bus.stage_rst_n), 0);
    run_to(27); chk("s6_rst_e27", 32'(bus.stage_rst_n), 1);
`endif

    // Stage 1 never acks: timeout after 8 edges in WAIT_ACK
    bus.stage_ack = 3'b101;
    do_reset();
    run_to(9);  chk("s2_e9", 32'(bus.stage_rst_n), 3);
    run_to(16);
    chk("s2_err_e16", 32'(bus.seq_err), 0);
    chk("s2_rst_e16", 32'(bus.stage_rst_n), 3);
    run_to(17);
    chk("s2_err_e17",   32'(bus.seq_err), 1);
    chk("s2_stage_e17", 32'(bus.err_stage), 1);
    chk("s2_rst_e17",   32'(bus.stage_rst_n), 1);
    chk("s2_done_e17",  32'(bus.seq_done), 0);
    bus.stage_ack = 3'b111;
    run_to(20);
    chk("s2_sticky_err", 32'(bus.seq_err), 1);
    chk("s2_sticky_rst", 32'(bus.stage_rst_n), 1);
    bus.soft_rst_req = 1'b1;
    run_to(21);
`ifndef RSTSEQ_REVERSE_ASSERT_EN
    chk("s2_soft_err",   32'(bus.seq_err), 0);
    chk("s2_soft_stage", 32'(bus.err_stage), 0);
    chk("s2_soft_rst",   32'(bus.stage_rst_n), 0);
`else
    chk("s2_soft_err",   32'(bus.seq_err), 1);
    run_to(22);
    chk("s2_assert_err", 32'(bus.seq_err), 0);
    chk("s2_assert_rst", 32'(bus.stage_rst_n), 0);
`endif
    bus.soft_rst_req = 1'b0;

    // Ack arriving on the last timeout edge wins
    bus.stage_ack = 3'b101;
    do_reset();
    run_to(16);
    bus.stage_ack = 3'b111;
    run_to(17);
    chk("s2b_err_e17", 32'(bus.seq_err), 0);
    chk("s2b_rst_e17", 32'(bus.stage_rst_n), 3);
    run_to(20); chk("s2b_e20", 32'(bus.stage_rst_n), 3);
    run_to(21); chk("s2b_e21", 32'(bus.stage_rst_n), 7);

    // rst_n dropped between edges, mid-DELAY of stage 1
    do_reset();
    run_to(7); chk("s4_e7", 32'(bus.stage_rst_n), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("s4_async_rst",  32'(bus.stage_rst_n), 0);
    chk("s4_async_done", 32'(bus.seq_done), 0);
    release_reset();
    run_to(3); chk("s4_re_e3", 32'(bus.stage_rst_n), 0);
    run_to(4); chk("s4_re_e4", 32'(bus.stage_rst_n), 1);
    run_to(15); chk("s4_re_done", 32'(bus.seq_done), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("s4_async_done_in_done", 32'(bus.seq_done), 0);

    // Soft reset and the final ack on the same WAIT_ACK edge
    bus.stage_ack = 3'b011;
    release_reset();
    run_to(14); chk("s5_e14", 32'(bus.stage_rst_n), 7);
    bus.stage_ack    = 3'b111;
    bus.soft_rst_req = 1'b1;
    run_to(15);
    chk("s5_done_e15", 32'(bus.seq_done), 0);
`ifndef RSTSEQ_REVERSE_ASSERT_EN
    chk("s5_rst_e15", 32'(bus.stage_rst_n), 0);
`else
    chk("s5_rst_e15", 32'(bus.stage_rst_n), 7);
`endif
    bus.soft_rst_req = 1'b0;
    run_to(17); chk("s5_done_e17", 32'(bus.seq_done), 0);
`ifndef RSTSEQ_REVERSE_ASSERT_EN
    run_to(19); chk("s5_e19", 32'(bus.stage_rst_n), 0);
    run_to(20); chk("s5_e20", 32'(bus.stage_rst_n), 1);
`else
    run_to(18); chk("s5_e18", 32'(bus.stage_rst_n), 0);
    run_to(23); chk("s5_e23", 32'(bus.stage_rst_n), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
